// File: rtl/mem8x16_arbiter_if.sv
// Requester-side bundle for mem8x16_arbiter: two single-word command ports (A, B)
// and the shared completion / read-data return path.
interface mem8x16_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          a_valid;
    logic          a_ready;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          b_valid;
    logic          b_ready;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          a_done;
    logic          b_done;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output a_valid, a_we, a_addr, a_wdata,
        output b_valid, b_we, b_addr, b_wdata,
        input  a_ready, b_ready, a_done, b_done, rsp_rdata
    );

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata,
        input  b_valid, b_we, b_addr, b_wdata,
        output a_ready, b_ready, a_done, b_done, rsp_rdata
    );
endinterface

// File: rtl/mem8x16_arbiter.sv
// Round-robin controller serialising single-word commands from two requesters onto
// one synchronous-read DFF memory, with an optional zero-fill pass after reset.
module mem8x16_arbiter #(
    parameter int DW         = 16,
    parameter int AW         = 3,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    mem8x16_arbiter_if.slave req,
    output logic             busy,
    output logic             init_done,
    output logic             mem_cs,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_din,
    input  logic [DW-1:0]    mem_dout
);
    localparam int          ROWS      = 1 << AW;
    localparam logic [AW:0] INIT_LAST = (AW+1)'(ROWS);
    localparam logic        OWN_B     = 1'b1;

    typedef enum logic [2:0] {INIT, IDLE, ACCESS, RDWAIT, RESP} state_t;

    state_t        state_reg, state_next;
    logic          owner_reg, owner_next;
    logic          rr_last_reg, rr_last_next;
    logic          cmd_we_reg, cmd_we_next;
    logic [AW:0]   init_cnt_reg, init_cnt_next;
    logic          init_done_reg, init_done_next;
    logic [DW-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic          mem_cs_reg, mem_cs_next;
    logic          mem_we_reg, mem_we_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_din_reg, mem_din_next;

    // Index 0 is requester A, index 1 is requester B.
    logic [1:0]         req_valid, req_we, req_ready, req_done;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][DW-1:0] req_wdata;
    logic               grant_any, grant_sel;

    assign req_valid = {req.b_valid, req.a_valid};
    assign req_we    = {req.b_we, req.a_we};
    assign req_addr  = {req.b_addr, req.a_addr};
    assign req_wdata = {req.b_wdata, req.a_wdata};

    // On contention the requester that did not win last time gets the slot.
    assign grant_any = (state_reg == IDLE) && (|req_valid);
    assign grant_sel = (&req_valid) ? ~rr_last_reg : req_valid[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_ready[gi] = grant_any && (grant_sel == 1'(gi));
            assign req_done[gi]  = (state_reg == RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign req.a_ready   = req_ready[0];
    assign req.b_ready   = req_ready[1];
    assign req.a_done    = req_done[0];
    assign req.b_done    = req_done[1];
    assign req.rsp_rdata = rsp_rdata_reg;

    assign busy      = (state_reg != IDLE);
    assign init_done = init_done_reg;
    assign mem_cs    = mem_cs_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_din   = mem_din_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= INIT_CLEAR ? INIT : IDLE;
            owner_reg     <= 1'b0;
            rr_last_reg   <= OWN_B;
            cmd_we_reg    <= 1'b0;
            init_cnt_reg  <= '0;
            init_done_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            mem_cs_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_din_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            rr_last_reg   <= rr_last_next;
            cmd_we_reg    <= cmd_we_next;
            init_cnt_reg  <= init_cnt_next;
            init_done_reg <= init_done_next;
            rsp_rdata_reg <= rsp_rdata_next;
            mem_cs_reg    <= mem_cs_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_din_reg   <= mem_din_next;
        end
    end

    // Memory pins are registered, so each state programs the pins for the next cycle.
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        rr_last_next   = rr_last_reg;
        cmd_we_next    = cmd_we_reg;
        init_cnt_next  = init_cnt_reg;
        rsp_rdata_next = rsp_rdata_reg;
        mem_cs_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_din_next   = mem_din_reg;

        case (state_reg)
            INIT: begin
                // Stay in INIT until the last row's write has actually been presented.
                if (init_cnt_reg == INIT_LAST) begin
                    state_next = IDLE;
                end else begin
                    mem_cs_next   = 1'b1;
                    mem_we_next   = 1'b1;
                    mem_addr_next = init_cnt_reg[AW-1:0];
                    mem_din_next  = '0;
                    init_cnt_next = init_cnt_reg + (AW+1)'(1);
                end
            end
            IDLE: begin
                if (grant_any) begin
                    owner_next    = grant_sel;
                    rr_last_next  = grant_sel;
                    cmd_we_next   = req_we[grant_sel];
                    mem_cs_next   = 1'b1;
                    mem_we_next   = req_we[grant_sel];
                    mem_addr_next = req_addr[grant_sel];
                    mem_din_next  = req_wdata[grant_sel];
                    state_next    = ACCESS;
                end
            end
            ACCESS: begin
                if (cmd_we_reg) begin
                    rsp_rdata_next = '0;
                    state_next     = RESP;
                end else begin
                    mem_cs_next = 1'b1;
                    state_next  = RDWAIT;
                end
            end
            RDWAIT: begin
                rsp_rdata_next = mem_dout;
                state_next     = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        init_done_next = init_done_reg || (state_next != INIT);
    end
endmodule

// File: tb/tb_mem8x16_arbiter.sv
// Randomised self-checking bench for mem8x16_arbiter against a word-array model
// of the memory contents and the round-robin / latency rules.
module tb_mem8x16_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy, init_done, mem_cs, mem_we;
    logic [2:0]  mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout = 16'h0;

    mem8x16_arbiter_if #(.DW(16), .AW(3)) bus ();

    mem8x16_arbiter #(.DW(16), .AW(3), .INIT_CLEAR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req(bus), .busy(busy), .init_done(init_done),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Synchronous-read DFF memory macro.
    logic [15:0] mem_array [8];
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) mem_array[mem_addr] <= mem_din;
            else        mem_dout <= mem_array[mem_addr];
        end
    end

    int          total = 0;
    int          bad = 0;
    logic [15:0] ref_mem [8];
    bit          model_rr = 1'b1;

    task automatic set_req(input bit who, input bit valid, input bit we,
                           input logic [2:0] addr, input logic [15:0] wdata);
        if (who) begin
            bus.b_valid = valid; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
        end else begin
            bus.a_valid = valid; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0;
        model_rr = 1'b1;
    endtask

    task automatic do_reset(output bit ok);
        rst_n = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30 && !init_done; i++) @(negedge clk);
        ok = init_done;
        model_clear();
    endtask

    // Issues one command; lat is edges from accept to done (-1 on timeout).
    task automatic do_cmd(input bit who, input bit we, input logic [2:0] addr,
                          input logic [15:0] wdata, output int lat, output logic [15:0] rdata);
        int k;
        lat = -1;
        rdata = 16'hxxxx;
        @(negedge clk);
        set_req(who, 1'b1, we, addr, wdata);
        #1;
        k = 0;
        while (!(who ? bus.b_ready : bus.a_ready) && k < 50) begin
            @(negedge clk); #1; k++;
        end
        if (!(who ? bus.b_ready : bus.a_ready)) begin
            set_req(who, 1'b0, 1'b0, 3'd0, 16'h0);
            return;
        end
        @(posedge clk);
        model_rr = who;
        if (we) ref_mem[addr] = wdata;
        @(negedge clk);
        set_req(who, 1'b0, 1'b0, 3'd0, 16'h0);
        k = 0;
        while (k < 20) begin
            if (who ? bus.b_done : bus.a_done) begin
                lat = k + 1;
                rdata = bus.rsp_rdata;
                break;
            end
            @(negedge clk); k++;
        end
    endtask

    task automatic test_reset();
        int  next_addr;
        bit  seq_ok, ready_seen;
        set_req(1'b0, 1'b1, 1'b0, 3'd1, 16'h0);
        set_req(1'b1, 1'b1, 1'b1, 3'd2, 16'h1111);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({mem_cs, mem_we, mem_addr, mem_din, init_done, bus.a_done, bus.b_done,
             bus.a_ready, bus.b_ready, bus.rsp_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: cs=%b we=%b addr=%0d din=%h idone=%b done=%b%b rdy=%b%b rdata=%h required all 0",
                     mem_cs, mem_we, mem_addr, mem_din, init_done, bus.a_done, bus.b_done,
                     bus.a_ready, bus.b_ready, bus.rsp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_addr = 0; seq_ok = 1'b1; ready_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (init_done) break;
            if (bus.a_ready || bus.b_ready) ready_seen = 1'b1;
            if (mem_cs) begin
                if (!mem_we || mem_din !== 16'h0 || mem_addr !== 3'(next_addr)) seq_ok = 1'b0;
                next_addr++;
            end
        end
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        model_clear();
        total++;
        if (next_addr !== 8) begin
            bad++; $display("FAIL init_row_count: got %0d cs cycles required 8", next_addr);
        end
        total++;
        if (seq_ok !== 1'b1) begin
            bad++; $display("FAIL init_sequence: got out-of-order or nonzero row writes required we=1 din=0 addr 0..7");
        end
        total++;
        if (ready_seen !== 1'b0) begin
            bad++; $display("FAIL init_ready: got ready during INIT required none");
        end
        total++;
        if (init_done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL init_done: got init_done=%b busy=%b required 1 0", init_done, busy);
        end
    endtask

    task automatic test_write_read();
        int          lat;
        logic [15:0] rd, exp, wd;
        bit          who, we;
        logic [2:0]  addr;
        do_cmd(1'b0, 1'b1, 3'd3, 16'hBEEF, lat, rd);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL beef_write_latency: got %0d required 2", lat); end
        total++;
        if (rd !== 16'h0) begin bad++; $display("FAIL beef_write_rdata: got %h required 0000", rd); end
        do_cmd(1'b0, 1'b0, 3'd3, 16'h0, lat, rd);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL beef_read_latency: got %0d required 3", lat); end
        total++;
        if (rd !== 16'hBEEF) begin bad++; $display("FAIL beef_read_rdata: got %h required beef", rd); end
        for (int i = 0; i < 24; i++) begin
            who  = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = 3'($urandom_range(0, 7));
            wd   = 16'($urandom);
            exp  = we ? 16'h0 : ref_mem[addr];
            do_cmd(who, we, addr, wd, lat, rd);
            total++;
            if (lat !== (we ? 2 : 3)) begin
                bad++; $display("FAIL rand_latency[%0d]: got %0d required %0d", i, lat, we ? 2 : 3);
            end
            total++;
            if (rd !== exp) begin
                bad++; $display("FAIL rand_rdata[%0d] who=%0d we=%0d addr=%0d: got %h required %h",
                                i, who, we, addr, rd, exp);
            end
        end
    endtask

    task automatic test_round_robin();
        int          lat, grants, na, nb;
        logic [15:0] rd, v1, v6, exp;
        bit          q[$];
        bit          exp_owner, got, owner;
        v1 = 16'($urandom) | 16'h0100;
        v6 = 16'($urandom) | 16'h0200;
        do_cmd(1'b0, 1'b1, 3'd1, v1, lat, rd);
        do_cmd(1'b1, 1'b1, 3'd6, v6, lat, rd);
        grants = 0; na = 0; nb = 0;
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 3'd1, 16'h0);
        set_req(1'b1, 1'b1, 1'b0, 3'd6, 16'h0);
        exp_owner = ~model_rr;
        for (int i = 0; i < 52; i++) begin
            if (i == 40) begin
                set_req(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
                set_req(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
            end
            #1;
            if (bus.a_ready || bus.b_ready) begin
                got = bus.b_ready;
                total++;
                if (bus.a_ready && bus.b_ready) begin
                    bad++; $display("FAIL rr_single_ready: got both ready required one");
                end else if (got !== exp_owner) begin
                    bad++; $display("FAIL rr_order grant %0d: got %0d required %0d", grants, got, exp_owner);
                end
                q.push_back(got);
                model_rr = got;
                exp_owner = ~got;
                grants++;
                if (got) nb++; else na++;
            end
            if (bus.a_done || bus.b_done) begin
                owner = bus.b_done;
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rr_unexpected_done: got done from %0d required none", owner);
                end else begin
                    got = q.pop_front();
                    exp = got ? ref_mem[6] : ref_mem[1];
                    if (owner !== got || bus.rsp_rdata !== exp) begin
                        bad++; $display("FAIL rr_done: got owner %0d data %h required owner %0d data %h",
                                        owner, bus.rsp_rdata, got, exp);
                    end
                end
            end
            @(negedge clk);
        end
        total++;
        if (grants < 8 || q.size() != 0) begin
            bad++; $display("FAIL rr_throughput: got %0d grants %0d pending required >=8 and 0", grants, q.size());
        end
        total++;
        if (na - nb > 1 || nb - na > 1) begin
            bad++; $display("FAIL rr_fairness: got A=%0d B=%0d required difference <=1", na, nb);
        end
    endtask

    task automatic test_cross();
        int          lat;
        logic [15:0] rd;
        bit          ok;
        do_reset(ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL cross_reinit: got init_done=%b required 1", ok); end
        do_cmd(1'b1, 1'b1, 3'd7, 16'h1234, lat, rd);
        total++;
        if (lat !== 2) begin bad++; $display("FAIL cross_write_latency: got %0d required 2", lat); end
        do_cmd(1'b0, 1'b0, 3'd7, 16'h0, lat, rd);
        total++;
        if (rd !== 16'h1234 || lat !== 3) begin
            bad++; $display("FAIL cross_read: got %h lat %0d required 1234 lat 3", rd, lat);
        end
        for (int r = 0; r < 7; r++) begin
            do_cmd(1'($urandom_range(0, 1)), 1'b0, 3'(r), 16'h0, lat, rd);
            total++;
            if (rd !== ref_mem[r] || lat !== 3) begin
                bad++; $display("FAIL cleared_row%0d: got %h lat %0d required %h lat 3", r, rd, lat, ref_mem[r]);
            end
        end
    endtask

    task automatic test_reset_rdwait();
        int          lat, k;
        logic [15:0] rd;
        bit          done_seen;
        do_cmd(1'b0, 1'b1, 3'd2, 16'h5A5A, lat, rd);
        do_cmd(1'b0, 1'b0, 3'd2, 16'h0, lat, rd);
        total++;
        if (rd !== 16'h5A5A) begin bad++; $display("FAIL pre_reset_read: got %h required 5a5a", rd); end
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 3'd2, 16'h0);
        #1;
        k = 0;
        while (!bus.a_ready && k < 20) begin @(negedge clk); #1; k++; end
        total++;
        if (bus.a_ready !== 1'b1) begin
            bad++; $display("FAIL rdwait_grant: got no ready in 20 cycles required ready");
            set_req(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        @(posedge clk);
        #2;
        total++;
        if (mem_cs !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 3'd2) begin
            bad++; $display("FAIL rdwait_pins: got cs=%b we=%b addr=%0d required 1 0 2", mem_cs, mem_we, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_cs, mem_we, mem_addr, mem_din, init_done, bus.a_done, bus.b_done, bus.rsp_rdata} !== '0) begin
            bad++; $display("FAIL async_reset_outputs: got cs=%b we=%b addr=%0d din=%h idone=%b done=%b%b rdata=%h required all 0",
                            mem_cs, mem_we, mem_addr, mem_din, init_done, bus.a_done, bus.b_done, bus.rsp_rdata);
        end
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.a_done || bus.b_done) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 30 && !init_done; i++) begin
            @(negedge clk);
            if (bus.a_done || bus.b_done) done_seen = 1'b1;
        end
        model_clear();
        total++;
        if (done_seen !== 1'b0) begin bad++; $display("FAIL dropped_cmd_done: got done pulse required none"); end
        total++;
        if (init_done !== 1'b1) begin bad++; $display("FAIL rerun_init: got init_done=%b required 1", init_done); end
        do_cmd(1'b0, 1'b0, 3'd2, 16'h0, lat, rd);
        total++;
        if (rd !== ref_mem[2] || lat !== 3) begin
            bad++; $display("FAIL post_reset_row: got %h lat %0d required %h lat 3", rd, lat, ref_mem[2]);
        end
    endtask

    task automatic test_idle();
        bit cs_seen, busy_seen, done_seen;
        cs_seen = 1'b0; busy_seen = 1'b0; done_seen = 1'b0;
        repeat (2) @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            if (mem_cs) cs_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (bus.a_done || bus.b_done) done_seen = 1'b1;
        end
        total++;
        if (cs_seen !== 1'b0) begin bad++; $display("FAIL idle_cs: got mem_cs=1 required 0"); end
        total++;
        if (busy_seen !== 1'b0) begin bad++; $display("FAIL idle_busy: got busy=1 required 0"); end
        total++;
        if (done_seen !== 1'b0) begin bad++; $display("FAIL idle_done: got done pulse required none"); end
    endtask

    initial begin
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        test_reset();
        test_write_read();
        test_round_robin();
        test_cross();
        test_reset_rdwait();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion by 400000 required finish");
        $fatal(1, "watchdog expired");
    end
endmodule
